// File: rtl/vector_pkg.sv
// Shared sizes, opcode/width encodings and FSM state type for the vector ALU.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package vector_pkg;

    localparam int VLEN   = 512;
    localparam int SLICE  = 128;
    localparam int NSLICE = VLEN / SLICE;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_XOR = 2'b11
    } opcode_e;

    typedef enum logic [1:0] {
        EW8  = 2'b00,
        EW16 = 2'b01,
        EW32 = 2'b10,
        EW64 = 2'b11
    } elem_width_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/valu_slice.sv
// One 128-bit slice of lane-partitioned ADD/SUB/MUL/XOR; MUL only when VALU_MUL_EN is defined.
// Latency: purely combinational.
// Backpressure: none; the caller time-multiplexes this slice under its own FSM.
module valu_slice
    import vector_pkg::*;
(
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic [1:0]       opcode,
    input  logic [1:0]       elem_width,
    output logic [SLICE-1:0] res_lo,
    output logic [SLICE-1:0] res_hi
);

    // Returns {hi, lo} packed into the low 2w bits for one w-bit lane.
    // Operands arrive zero-extended, so the upper bits fold away per call site.
    function automatic logic [127:0] lane_calc(
        input logic [63:0] la,
        input logic [63:0] lb,
        input logic [1:0]  op,
        input logic [6:0]  w
    );
        logic [127:0] ax;
        logic [127:0] bx;
        logic [127:0] mask;
        logic [127:0] res;
        ax   = {64'd0, la};
        bx   = {64'd0, lb};
        mask = (128'd1 << w) - 128'd1;
        res  = '0;
        case (opcode_e'(op))
            OP_ADD: res = ax + bx;
            OP_SUB: res = ((ax - bx) & mask) | (128'(la < lb) << w);
            OP_MUL: begin
`ifdef VALU_MUL_EN
                res = ax * bx;
`else
                res = '0;
`endif
            end
            default: res = ax ^ bx;
        endcase
        return res;
    endfunction

    // Split the slice into lanes of the selected width; no carry crosses lanes.
    always_comb begin
        res_lo = '0;
        res_hi = '0;
        case (elem_width_e'(elem_width))
            EW8: begin
                for (int i = 0; i < SLICE / 8; i++)
                    {res_hi[8*i +: 8], res_lo[8*i +: 8]} =
                        16'(lane_calc(64'(a[8*i +: 8]), 64'(b[8*i +: 8]), opcode, 7'd8));
            end
            EW16: begin
                for (int i = 0; i < SLICE / 16; i++)
                    {res_hi[16*i +: 16], res_lo[16*i +: 16]} =
                        32'(lane_calc(64'(a[16*i +: 16]), 64'(b[16*i +: 16]), opcode, 7'd16));
            end
            EW32: begin
                for (int i = 0; i < SLICE / 32; i++)
                    {res_hi[32*i +: 32], res_lo[32*i +: 32]} =
                        64'(lane_calc(64'(a[32*i +: 32]), 64'(b[32*i +: 32]), opcode, 7'd32));
            end
            default: begin
                for (int i = 0; i < SLICE / 64; i++)
                    {res_hi[64*i +: 64], res_lo[64*i +: 64]} =
                        lane_calc(a[64*i +: 64], b[64*i +: 64], opcode, 7'd64);
            end
        endcase
    end

endmodule

// File: rtl/vector_alu.sv
// 512-bit vector ALU, one 128-bit slice per cycle; MUL support selected by VALU_MUL_EN.
// Latency: fixed 5 cycles from accepted start to the done/write_enable pulse.
// Backpressure: start is only sampled in IDLE; a start while busy is dropped, never queued.
module vector_alu
    import vector_pkg::*;
(
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic [1:0]      opcode,
    input  logic [1:0]      elem_width,
    input  logic [VLEN-1:0] A1,
    input  logic [VLEN-1:0] A2,
    output logic            busy,
    output logic            done,
    output logic            write_enable,
    output logic            err,
    output logic [VLEN-1:0] A3,
    output logic [VLEN-1:0] A4
);

    state_e                state_q;
    state_e                state_d;
    logic                  accept;
    logic                  last_slice;
    logic                  op_unsupported;
    logic [1:0]            slice_cnt_q;
    logic [VLEN-1:0]       a1_q;
    logic [VLEN-1:0]       a2_q;
    logic [1:0]            opcode_q;
    logic [1:0]            elem_width_q;
    // Only the lower slices need staging; the top slice goes straight to A3/A4.
    logic [VLEN-SLICE-1:0] stage_lo_q;
    logic [VLEN-SLICE-1:0] stage_hi_q;
    logic [SLICE-1:0]      slice_a;
    logic [SLICE-1:0]      slice_b;
    logic [SLICE-1:0]      slice_lo;
    logic [SLICE-1:0]      slice_hi;

    assign last_slice = (slice_cnt_q == 2'(NSLICE - 1));
    assign slice_a    = a1_q[slice_cnt_q*SLICE +: SLICE];
    assign slice_b    = a2_q[slice_cnt_q*SLICE +: SLICE];

`ifdef VALU_MUL_EN
    assign op_unsupported = 1'b0;
`else
    assign op_unsupported = (opcode_q == OP_MUL);
`endif

    valu_slice u_slice (
        .a          (slice_a),
        .b          (slice_b),
        .opcode     (opcode_q),
        .elem_width (elem_width_q),
        .res_lo     (slice_lo),
        .res_hi     (slice_hi)
    );

    // Next-state decode: IDLE -> EXEC (4 slices) -> DONE (1 cycle) -> IDLE.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_EXEC;
                    accept  = 1'b1;
                end
            end
            ST_EXEC: begin
                if (last_slice)
                    state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State register and slice counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            slice_cnt_q <= 2'd0;
        end else begin
            state_q <= state_d;
            if (accept)
                slice_cnt_q <= 2'd0;
            else if (state_q == ST_EXEC)
                slice_cnt_q <= slice_cnt_q + 2'd1;
        end
    end

    // Status outputs registered from the next state so nothing is combinational.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy         <= 1'b0;
            done         <= 1'b0;
            write_enable <= 1'b0;
            err          <= 1'b0;
        end else begin
            busy         <= (state_d != ST_IDLE);
            done         <= (state_d == ST_DONE);
            write_enable <= (state_d == ST_DONE);
            err          <= (state_d == ST_DONE) && op_unsupported;
        end
    end

    // Capture operands and controls on an accepted start; later input changes are ignored.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a1_q         <= '0;
            a2_q         <= '0;
            opcode_q     <= 2'd0;
            elem_width_q <= 2'd0;
        end else if (accept) begin
            a1_q         <= A1;
            a2_q         <= A2;
            opcode_q     <= opcode;
            elem_width_q <= elem_width;
        end
    end

    // Stage lower slices; A3/A4 update only with the last slice so they hold between dones.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stage_lo_q <= '0;
            stage_hi_q <= '0;
            A3         <= '0;
            A4         <= '0;
        end else if (state_q == ST_EXEC) begin
            if (last_slice) begin
                A3 <= {slice_lo, stage_lo_q};
                A4 <= {slice_hi, stage_hi_q};
            end else begin
                stage_lo_q[slice_cnt_q*SLICE +: SLICE] <= slice_lo;
                stage_hi_q[slice_cnt_q*SLICE +: SLICE] <= slice_hi;
            end
        end
    end

endmodule

// File: tb/tb_vector_alu.sv
// Self-checking bench for vector_alu against a lane-level arithmetic model.
// Latency: model expects done 5 cycles after an accepted start.
// Backpressure: model drops any start seen while the operation is in flight.
`timescale 1ns/1ps
module tb_vector_alu;
    import vector_pkg::*;

    typedef struct packed {
        logic [VLEN-1:0] a3;
        logic [VLEN-1:0] a4;
        logic            err;
    } res_t;

    logic            clk;
    logic            reset_n;
    logic            start;
    logic [1:0]      opcode;
    logic [1:0]      elem_width;
    logic [VLEN-1:0] A1;
    logic [VLEN-1:0] A2;
    logic            busy;
    logic            done;
    logic            write_enable;
    logic            err;
    logic [VLEN-1:0] A3;
    logic [VLEN-1:0] A4;

    vector_alu dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .opcode       (opcode),
        .elem_width   (elem_width),
        .A1           (A1),
        .A2           (A2),
        .busy         (busy),
        .done         (done),
        .write_enable (write_enable),
        .err          (err),
        .A3           (A3),
        .A4           (A4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int              n_chk   = 0;
    int              n_fail  = 0;
    int              cyc     = 0;
    bit              chk_en  = 1'b0;
    bit              to_flag = 1'b0;
    bit              lit_armed = 1'b0;
    string           lit_name  = "";
    logic [VLEN-1:0] lit_a3;
    logic [VLEN-1:0] lit_a4;
    logic            lit_err;
    int              lit_cyc = 0;

    bit              pending = 1'b0;
    int              acc     = 0;
    res_t            pend;
    logic            m_busy;
    logic            m_done;
    logic            m_err;
    logic [VLEN-1:0] m_a3;
    logic [VLEN-1:0] m_a4;

    // Element-wise reference: slice each operand into w-bit lanes and apply plain arithmetic.
    function automatic res_t model_calc(input logic [VLEN-1:0] a1, input logic [VLEN-1:0] a2,
                                        input logic [1:0] op, input logic [1:0] ew);
        res_t            r;
        int              w;
        logic [VLEN-1:0] vmask;
        logic [127:0]    m;
        logic [127:0]    a;
        logic [127:0]    b;
        logic [127:0]    full;
        logic [127:0]    lo;
        logic [127:0]    hi;
        r     = '0;
        w     = 8 << ew;
        vmask = (VLEN'(1) << w) - VLEN'(1);
        m     = (128'd1 << w) - 128'd1;
        for (int i = 0; i < VLEN / w; i++) begin
            a = 128'((a1 >> (i * w)) & vmask);
            b = 128'((a2 >> (i * w)) & vmask);
            case (op)
                2'b00: begin full = a + b; lo = full & m; hi = full >> w; end
                2'b01: begin lo = (a - b) & m; hi = (a < b) ? 128'd1 : 128'd0; end
                2'b10: begin
`ifdef VALU_MUL_EN
                    full = a * b; lo = full & m; hi = full >> w;
`else
                    lo = '0; hi = '0; r.err = 1'b1;
`endif
                end
                default: begin lo = a ^ b; hi = '0; end
            endcase
            r.a3 = r.a3 | (VLEN'(lo) << (i * w));
            r.a4 = r.a4 | (VLEN'(hi) << (i * w));
        end
        return r;
    endfunction

    function automatic logic [VLEN-1:0] rand_vec();
        logic [VLEN-1:0] v;
        for (int i = 0; i < VLEN / 32; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Transaction-level model: one op in flight, result due 4 edges after acceptance.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending <= 1'b0;
            m_busy  <= 1'b0;
            m_done  <= 1'b0;
            m_err   <= 1'b0;
            m_a3    <= '0;
            m_a4    <= '0;
        end else begin
            m_done <= pending && (cyc == acc + 4);
            m_err  <= pending && (cyc == acc + 4) && pend.err;
            if (pending && (cyc == acc + 4)) begin
                m_a3 <= pend.a3;
                m_a4 <= pend.a4;
            end
            if (!pending && start) begin
                pending <= 1'b1;
                acc     <= cyc;
                pend    <= model_calc(A1, A2, opcode, elem_width);
                m_busy  <= 1'b1;
            end else begin
                m_busy <= pending && (cyc <= acc + 4);
                if (pending && (cyc == acc + 5)) pending <= 1'b0;
            end
        end
    end

    task automatic chk1(input string name, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chkv(input string name, input logic [VLEN-1:0] act, input logic [VLEN-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Every cycle: DUT against model; on armed dones also against hand-computed literals.
    always @(negedge clk) begin
        if (chk_en) begin
            chk1("busy", busy, m_busy);
            chk1("done", done, m_done);
            chk1("write_enable", write_enable, m_done);
            chk1("err", err, m_err);
            chkv("A3", A3, m_a3);
            chkv("A4", A4, m_a4);
            chk1("wait_bound", to_flag, 1'b0);
            if (!reset_n) begin
                chkv("A3_reset", A3, '0);
                chkv("A4_reset", A4, '0);
                chk1("busy_reset", busy, 1'b0);
                chk1("we_reset", write_enable, 1'b0);
            end
            if (lit_armed && (done === 1'b1)) begin
                chkv({lit_name, "_A3"}, A3, lit_a3);
                chkv({lit_name, "_A4"}, A4, lit_a4);
                chk1({lit_name, "_err"}, err, lit_err);
                chkv({lit_name, "_model_A3"}, m_a3, lit_a3);
                chkv({lit_name, "_model_A4"}, m_a4, lit_a4);
                chki({lit_name, "_latency"}, cyc - lit_cyc, 5);
            end
        end
    end

    task automatic set_lit(input string name, input logic [VLEN-1:0] e3,
                           input logic [VLEN-1:0] e4, input logic e_err);
        lit_name = name;
        lit_a3   = e3;
        lit_a4   = e4;
        lit_err  = e_err;
    endtask

    // Issue one op from a negedge; scramble inputs after acceptance; optionally poke start while busy.
    task automatic run_op(input logic [1:0] op, input logic [1:0] ew, input logic [VLEN-1:0] a1,
                          input logic [VLEN-1:0] a2, input bit poke, input bit arm);
        int guard;
        int lat;
        guard = 0;
        while (busy !== 1'b0 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 20) to_flag = 1'b1;
        opcode     = op;
        elem_width = ew;
        A1         = a1;
        A2         = a2;
        lit_cyc    = cyc;
        lit_armed  = arm;
        start      = 1'b1;
        lat        = 0;
        while (lat < 12) begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                start      = 1'b0;
                A1         = rand_vec();
                A2         = rand_vec();
                opcode     = 2'($urandom_range(0, 3));
                elem_width = 2'($urandom_range(0, 3));
            end
            if (poke && lat == 2) start = 1'b1;
            if (poke && lat == 3) start = 1'b0;
            if (done === 1'b1) break;
        end
        if (lat >= 12) to_flag = 1'b1;
        @(negedge clk);
        lit_armed = 1'b0;
    endtask

    logic [VLEN-1:0] v1;
    logic [VLEN-1:0] v2;

    initial begin
        reset_n    = 1'b0;
        start      = 1'b0;
        opcode     = 2'b00;
        elem_width = 2'b00;
        A1         = '0;
        A2         = '0;
        repeat (2) @(posedge clk);
        #1 chk_en = 1'b1;
        repeat (2) @(negedge clk);
        #2 reset_n = 1'b1;
        @(negedge clk);

        v1 = {64{8'hFF}};
        v2 = {64{8'h01}};
        set_lit("add_ew8", '0, {64{8'h01}}, 1'b0);
        run_op(2'b00, 2'b00, v1, v2, 1'b0, 1'b1);

        v1 = {16{32'd5}};
        v2 = {16{32'd7}};
        set_lit("sub_ew32", {16{32'hFFFF_FFFE}}, {16{32'h0000_0001}}, 1'b0);
        run_op(2'b01, 2'b10, v1, v2, 1'b0, 1'b1);

        v1 = {8{64'hFFFF_FFFF_FFFF_FFFF}};
        v2 = {8{64'd2}};
`ifdef VALU_MUL_EN
        set_lit("mul_ew64", {8{64'hFFFF_FFFF_FFFF_FFFE}}, {8{64'd1}}, 1'b0);
`else
        set_lit("mul_ew64", '0, '0, 1'b1);
`endif
        run_op(2'b10, 2'b11, v1, v2, 1'b0, 1'b1);

        v1 = rand_vec();
        set_lit("xor_ew16", '0, '0, 1'b0);
        run_op(2'b11, 2'b01, v1, v1, 1'b1, 1'b1);

        // Abort an ADD two cycles into EXEC; no write_enable may follow.
        opcode     = 2'b00;
        elem_width = 2'($urandom_range(0, 3));
        A1         = rand_vec();
        A2         = rand_vec();
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        #2 reset_n = 1'b1;
        repeat (10) @(negedge clk);

        for (int i = 0; i < 40; i++) begin
            run_op(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), rand_vec(), rand_vec(),
                   1'($urandom_range(0, 1)), 1'b0);
        end

        // Start held high: acceptance every 6 cycles with fresh operands each cycle.
        start = 1'b1;
        for (int i = 0; i < 36; i++) begin
            opcode     = 2'($urandom_range(0, 3));
            elem_width = 2'($urandom_range(0, 3));
            A1         = rand_vec();
            A2         = rand_vec();
            @(negedge clk);
        end
        start = 1'b0;
        repeat (10) @(negedge clk);

        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
